// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel-output alignment.
// The counters address the frame buffer. Decoded blanking, sync and marker
// flags are delayed by the buffer read latency. One output register then
// emits de/hs/vs/vrgb/markers together, so they stay cycle-aligned.
module vga_timing_gen #(
  parameter int              H_ACTIVE   = 800,
  parameter int              H_FP       = 56,
  parameter int              H_SYNC     = 120,
  parameter int              H_BP       = 64,
  parameter int              V_ACTIVE   = 600,
  parameter int              V_FP       = 37,
  parameter int              V_SYNC     = 6,
  parameter int              V_BP       = 23,
  parameter bit              HS_POL     = 1'b1,
  parameter bit              VS_POL     = 1'b1,
  parameter int              DW         = 12,
  parameter int              RD_LAT     = 1,
  parameter logic [DW-1:0]   BORDER_RGB = '0
) (
  input  logic                                               pclk,
  input  logic                                               rst,
  input  logic                                               en,
  input  logic [DW-1:0]                                      pdata,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       hcount,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       vcount,
  output logic                                               fetch_en,
  output logic [DW-1:0]                                      vrgb,
  output logic                                               de,
  output logic                                               hs,
  output logic                                               vs,
  output logic                                               frame_start,
  output logic                                               line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // One pipeline entry. The all-zero value is the idle entry.
  typedef struct packed {
    logic act;
    logic hsy;
    logic vsy;
    logic fs;
    logic ls;
  } tap_t;

  tap_t dec;  // decode of the current counter position
  tap_t dly;  // decode delayed to line up with pdata

  // Raster counters: park at (0,0) while disabled, otherwise scan and wrap
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!en) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
    end else begin
      hcount <= hcount + HW'(1);
    end
  end

  // Position decode. Gating with en makes a disabled cycle an idle entry.
  always_comb begin
    dec     = '0;
    dec.act = en && (hcount < H_ACT) && (vcount < V_ACT);
    dec.hsy = en && (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    dec.vsy = en && (vcount >= VS_FIRST) && (vcount <= VS_LAST);
    dec.fs  = en && (hcount == '0) && (vcount == '0);
    dec.ls  = en && (hcount == '0);
  end

  // Read enable. It is held low during reset, even though the counters sit at (0,0).
  assign fetch_en = dec.act & ~rst;

  generate
    if (RD_LAT == 0) begin : g_no_delay
      assign dly = dec;
    end else begin : g_delay
      tap_t sr [RD_LAT];

      // Delay line that matches the frame-buffer read latency
      always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT; i++) sr[i] <= '0;
        end else begin
          sr[0] <= dec;
          for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
        end
      end

      assign dly = sr[RD_LAT-1];
    end
  endgenerate

  // Output register: sync, enable, markers and colour leave together
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vrgb        <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      vrgb        <= dly.act ? pdata : BORDER_RGB;
      de          <= dly.act;
      hs          <= dly.hsy ? HS_POL : ~HS_POL;
      vs          <= dly.vsy ? VS_POL : ~VS_POL;
      frame_start <= dly.fs;
      line_start  <= dly.ls;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// It uses a default 800x600 instance and a tiny raster instance with a
// 3-cycle read latency and active-low hsync.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic en_s = 1'b0;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  // ---------------- default instance ----------------
  logic [11:0] pdata_d = '0;
  logic [10:0] hcount_d;
  logic [9:0]  vcount_d;
  logic        fetch_en_d, de_d, hs_d, vs_d, fs_d, ls_d;
  logic [11:0] vrgb_d;

  vga_timing_gen u_dut (
    .pclk(pclk), .rst(rst), .en(en), .pdata(pdata_d),
    .hcount(hcount_d), .vcount(vcount_d), .fetch_en(fetch_en_d),
    .vrgb(vrgb_d), .de(de_d), .hs(hs_d), .vs(vs_d),
    .frame_start(fs_d), .line_start(ls_d)
  );

  // 1-cycle model RAM whose content at (x,y) is the low 12 bits of {y,x}
  always @(posedge pclk) pdata_d <= {vcount_d[0], hcount_d};

  // ---------------- small raster instance ----------------
  logic [11:0] pdata_s = '0;
  logic [11:0] ram_r1 = '0, ram_r2 = '0;
  logic [2:0]  hcount_s, vcount_s;
  logic        fetch_en_s, de_s, hs_s, vs_s, fs_s, ls_s;
  logic [11:0] vrgb_s;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .DW(12), .RD_LAT(3), .BORDER_RGB(12'h000)
  ) u_small (
    .pclk(pclk), .rst(rst), .en(en_s), .pdata(pdata_s),
    .hcount(hcount_s), .vcount(vcount_s), .fetch_en(fetch_en_s),
    .vrgb(vrgb_s), .de(de_s), .hs(hs_s), .vs(vs_s),
    .frame_start(fs_s), .line_start(ls_s)
  );

  // 3-cycle model RAM whose content at (x,y) is {6'b0,y,x}
  always @(posedge pclk) begin
    ram_r1  <= {6'b0, vcount_s, hcount_s};
    ram_r2  <= ram_r1;
    pdata_s <= ram_r2;
  end

  // ---------------- driver tasks ----------------
  // Assert reset, then release it mid-cycle so the next rising edge is cycle 1
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    #5 rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [38:0] got, exp;
    logic [11:0] got_s, exp_s;
    en = 1'b1; en_s = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    got = {hcount_d, vcount_d, fetch_en_d, vrgb_d, de_d, hs_d, vs_d, fs_d, ls_d};
    exp = {11'd0, 10'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_default got=%h exp=%h", got, exp);
    end
    // Small instance: hs idles high because its sync polarity is active-low
    got_s = {de_s, hs_s, vs_s, fs_s, ls_s, fetch_en_s, hcount_s, vcount_s};
    exp_s = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
    checks++;
    if (got_s !== exp_s) begin
      failures++;
      $display("FAIL reset_small got=%h exp=%h", got_s, exp_s);
    end
    en_s = 1'b0;
  endtask

  // Two full lines plus margin, compared every cycle against the raster model
  task automatic test_default_raster();
    int lfail = 0;
    logic [38:0] got, exp;
    en = 1'b1;
    do_reset();
    for (int k = 1; k <= 2 * 1040 + 50; k++) begin
      int p, h, v, hc, vc;
      logic act, e_hs, e_vs, e_fs, e_ls, e_fetch;
      logic [11:0] e_rgb;
      @(posedge pclk); #1;
      hc = k % 1040; vc = (k / 1040) % 666;
      e_fetch = (hc < 800) && (vc < 600);
      p = k - 2;
      act = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_ls = 1'b0; e_rgb = 12'h000;
      if (p >= 0) begin
        h = p % 1040; v = (p / 1040) % 666;
        act  = (h < 800) && (v < 600);
        e_hs = (h >= 856) && (h <= 975);
        e_vs = (v >= 637) && (v <= 642);
        e_fs = (p % 692640) == 0;
        e_ls = (h == 0);
        e_rgb = act ? 12'((v % 2) * 2048 + h) : 12'h000;
      end
      got = {hcount_d, vcount_d, fetch_en_d, vrgb_d, de_d, hs_d, vs_d, fs_d, ls_d};
      exp = {11'(hc), 10'(vc), e_fetch, e_rgb, act, e_hs, e_vs, e_fs, e_ls};
      checks++;
      if (got !== exp) begin
        failures++; lfail++;
        $display("FAIL default_raster k=%0d got=%h exp=%h", k, got, exp);
        if (lfail >= 5) break;
      end
    end
  endtask

  // en dropped at (300,10) and re-raised later
  task automatic test_en_drop();
    logic [38:0] got, exp;
    en = 1'b1;
    do_reset();
    repeat (10 * 1040 + 300) @(posedge pclk);
    #1;
    checks++;
    if ({hcount_d, vcount_d} !== {11'd300, 10'd10}) begin
      failures++;
      $display("FAIL en_drop_position got=%0d,%0d exp=300,10", hcount_d, vcount_d);
    end
    en = 1'b0;
    #1;
    checks++;
    if (fetch_en_d !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_fetch got=%b exp=0", fetch_en_d);
    end
    repeat (2) @(posedge pclk);
    #1;
    got = {hcount_d, vcount_d, fetch_en_d, vrgb_d, de_d, hs_d, vs_d, fs_d, ls_d};
    exp = '0;
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL en_drop_idle got=%h exp=%h", got, exp);
    end
    repeat (5) @(posedge pclk);
    #1;
    got = {hcount_d, vcount_d, fetch_en_d, vrgb_d, de_d, hs_d, vs_d, fs_d, ls_d};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL en_hold_idle got=%h exp=%h", got, exp);
    end
    // Re-enable: cycle counting restarts at (0,0); frame_start appears 2 cycles later
    en = 1'b1;
    #1;
    checks++;
    if (fetch_en_d !== 1'b1) begin
      failures++;
      $display("FAIL en_rise_fetch got=%b exp=1", fetch_en_d);
    end
    @(posedge pclk); #1;
    checks++;
    if ({hcount_d, fs_d} !== {11'd1, 1'b0}) begin
      failures++;
      $display("FAIL en_rise_c1 got=%0d/%b exp=1/0", hcount_d, fs_d);
    end
    @(posedge pclk); #1;
    checks++;
    if ({fs_d, ls_d, de_d, hcount_d} !== {1'b1, 1'b1, 1'b1, 11'd2}) begin
      failures++;
      $display("FAIL en_rise_c2 got=%b%b%b/%0d exp=111/2", fs_d, ls_d, de_d, hcount_d);
    end
    @(posedge pclk); #1;
    checks++;
    if ({fs_d, ls_d} !== 2'b00) begin
      failures++;
      $display("FAIL en_rise_c3 got=%b%b exp=00", fs_d, ls_d);
    end
  endtask

  // Asynchronous reset asserted while hsync is active
  task automatic test_reset_mid_sync();
    logic [38:0] got, exp;
    bit found = 1'b0;
    en = 1'b1;
    do_reset();
    for (int k = 1; k <= 2000; k++) begin
      @(posedge pclk); #1;
      if (hs_d === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_sync_wait got=no_hsync exp=hsync_within_2000");
    end
    repeat (3) @(posedge pclk);
    #3 rst = 1'b1;
    #1;
    got = {hcount_d, vcount_d, fetch_en_d, vrgb_d, de_d, hs_d, vs_d, fs_d, ls_d};
    exp = '0;
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL mid_sync_async_reset got=%h exp=%h", got, exp);
    end
    #2 rst = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({fs_d, hcount_d, vcount_d} !== {1'b1, 11'd2, 10'd0}) begin
      failures++;
      $display("FAIL mid_sync_restart got=%b/%0d/%0d exp=1/2/0", fs_d, hcount_d, vcount_d);
    end
  endtask

  // Small raster: 8-cycle line, 48-cycle frame, latency 4, active-low hsync
  task automatic test_small_raster();
    int lfail = 0;
    logic [23:0] got, exp;
    en = 1'b0;
    en_s = 1'b1;
    do_reset();
    for (int k = 1; k <= 110; k++) begin
      int p, h, v, hc, vc;
      logic act, e_hs, e_vs, e_fs, e_ls, e_fetch;
      logic [11:0] e_rgb;
      @(posedge pclk); #1;
      hc = k % 8; vc = (k / 8) % 6;
      e_fetch = (hc < 4) && (vc < 3);
      p = k - 4;
      act = 1'b0; e_hs = 1'b1; e_vs = 1'b0; e_fs = 1'b0; e_ls = 1'b0; e_rgb = 12'h000;
      if (p >= 0) begin
        h = p % 8; v = (p / 8) % 6;
        act  = (h < 4) && (v < 3);
        e_hs = !((h >= 5) && (h <= 6));
        e_vs = (v == 4);
        e_fs = (p % 48) == 0;
        e_ls = (h == 0);
        e_rgb = act ? 12'(v * 8 + h) : 12'h000;
      end
      got = {hcount_s, vcount_s, fetch_en_s, e_rgb === e_rgb ? vrgb_s : 12'h000, de_s, hs_s, vs_s, fs_s, ls_s};
      exp = {3'(hc), 3'(vc), e_fetch, e_rgb, act, e_hs, e_vs, e_fs, e_ls};
      checks++;
      if (got !== exp) begin
        failures++; lfail++;
        $display("FAIL small_raster k=%0d got=%h exp=%h", k, got, exp);
        if (lfail >= 5) break;
      end
    end
    en_s = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_default_raster();
    test_en_drop();
    test_reset_mid_sync();
    test_small_raster();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time in case any wait stalls
  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish_before_2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
